switch_debounce4: RTL

- Upstream input-conditioning stage for the 4-to-16 decoder function block.
- Takes four raw, asynchronous slide-switch/push-button levels and synchronises each to clk.
- Debounces each bit independently.
- Presents clean registered levels A, B, C, D that drive the decoder's {A,B,C,D} input bus directly, plus a one-cycle change strobe for downstream logging or counting.

---
 rtl/switch_debounce4.sv | 89 ++++++++
 1 files changed

// File: rtl/switch_debounce4.sv
// switch_debounce4: two-flop synchroniser and independent per-bit debounce for four raw
// switch levels. Drives clean registered A..D (decoder input bus), a one-cycle change strobe
// and a combinational "nothing pending" flag.
module switch_debounce4 #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned CNT_W           = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] sw_in,
    output logic       A,
    output logic       B,
    output logic       C,
    output logic       D,
    output logic       changed,
    output logic       stable
);

    // Count value on which a still-mismatching bit finally flips.
    localparam logic [CNT_W-1:0] TermCnt = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [3:0]       sync1_q, sync2_q;
    logic [3:0]       out_q, out_d;
    logic [CNT_W-1:0] cnt_q [4];
    logic [CNT_W-1:0] cnt_d [4];
    logic [3:0]       flip;
    logic             changed_q, changed_d;

    // Per-bit debounce: count consecutive mismatch cycles, flip on the terminal count.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            cnt_d[i] = '0;
            out_d[i] = out_q[i];
            flip[i]  = 1'b0;
            if (sync2_q[i] != out_q[i]) begin
                if (cnt_q[i] == TermCnt) begin
                    out_d[i] = sync2_q[i];
                    flip[i]  = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
        changed_d = |flip;
    end

    // State registers; reset discards any in-flight debounce, including the synchroniser.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            out_q     <= '0;
            changed_q <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q   <= sync_in_mask(sw_in);
            sync2_q   <= sync1_q;
            out_q     <= out_d;
            changed_q <= changed_d;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Identity helper kept separate so the raw asynchronous sample point is easy to find.
    function automatic logic [3:0] sync_in_mask(input logic [3:0] raw);
        return raw;
    endfunction

    // Stable only when no bit has a pending mismatch count.
    always_comb begin
        stable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (cnt_q[i] != '0) begin
                stable = 1'b0;
            end
        end
    end

    assign A       = out_q[3];
    assign B       = out_q[2];
    assign C       = out_q[1];
    assign D       = out_q[0];
    assign changed = changed_q;

endmodule
